// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: modulus MAX_VAL, wrap or saturate, tc pulse, sticky wrap_flag.
// Ports: clk, rst (async low), en, load, updown, data, flag_clr -> data_out, tc, wrap_flag.
// Optional macro UDCNT_PRESCALE_EN: step only on every PRESCALE-th enabled cycle.
module updown_counter_param #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             updown,
  input  logic [WIDTH-1:0] data,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             wrap_flag
);

  localparam longint LIMIT = (longint'(1) << WIDTH) - 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be >= 1");
  end
  if (longint'(MAX_VAL) > LIMIT || MAX_VAL < 0) begin : g_bad_max
    $error("updown_counter_param: MAX_VAL out of range for WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("updown_counter_param: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  logic             hit;
  logic             step;
  logic             bnd;
  logic [WIDTH-1:0] clamp;

`ifdef UDCNT_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE+1);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE-1);

  logic [PW-1:0] pcnt;

  assign hit = (pcnt == PLAST);

  // Counts enabled cycles; wraps to 0 on the cycle that steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (load) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= hit ? '0 : pcnt + PW'(1);
    end
  end
`else
  assign hit = 1'b1;
`endif

  assign step  = en & ~load & hit;
  // Explicit compare against MAXV so a modulus below 2**WIDTH-1 wraps correctly.
  assign bnd   = updown ? (data_out == MAXV) : (data_out == '0);
  assign clamp = (data > MAXV) ? MAXV : data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      tc       <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        data_out <= clamp;
      end else if (step) begin
        if (bnd) begin
          tc <= 1'b1;
          if (!SATURATE) begin
            data_out <= updown ? '0 : MAXV;
          end
        end else begin
          data_out <= updown ? data_out + WIDTH'(1)
                             : data_out - WIDTH'(1);
        end
      end
    end
  end

  // Set has priority over clear when both happen on one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_flag <= 1'b0;
    end else if (step && bnd) begin
      wrap_flag <= 1'b1;
    end else if (flag_clr) begin
      wrap_flag <= 1'b0;
    end
  end

endmodule
